// File: rtl/io_input_conditioner_pkg.sv
// Shared constants and helpers for the board input conditioner.
package io_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  localparam int INPORT0 = 0;
  localparam int INPORT1 = 1;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a consecutive-sample debouncer.
module debounce_bit
  import io_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the stable value restarts the count, so
  // the counter never runs past LAST.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Board button/switch front-end: debounced levels, press pulses and
// memory-mapped inport load strobes for the processor.
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_BTN         = 2,
  parameter int SW_WIDTH        = 10,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BTN-1:0]    button_raw,
  input  logic [SW_WIDTH-1:0]   switches_raw,
  output logic [NUM_BTN-1:0]    button_level,
  output logic [NUM_BTN-1:0]    button_press,
  output logic [SW_WIDTH-1:0]   switches_out,
  output logic                  switches_changed,
  output logic [DATA_WIDTH-1:0] inport_data,
  output logic [1:0]            inport_en
);

  localparam int BTN_LOAD = 1;

  logic [NUM_BTN-1:0]  btn_stable;
  logic [SW_WIDTH-1:0] sw_stable;
  logic [NUM_BTN-1:0]  level_dly_q, level_dly_d;
  logic [SW_WIDTH-1:0] sw_prev_q, sw_prev_d;

  // Keys are active-low on the board, so they idle (and reset) at 1.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (button_raw[i]),
      .stable (btn_stable[i])
    );
  end

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (switches_raw[i]),
      .stable (sw_stable[i])
    );
  end

  always_comb begin
    button_level     = ~btn_stable;
    switches_out     = sw_stable;
    level_dly_d      = button_level;
    sw_prev_d        = sw_stable;
    button_press     = button_level & ~level_dly_q;
    switches_changed = |(sw_stable ^ sw_prev_q);
    inport_data      = DATA_WIDTH'(sw_stable[SW_WIDTH-2:0]);
    // Select bit is read in the same cycle as the press, so a switch
    // update landing on the same edge is honoured.
    inport_en = 2'b00;
    if (button_press[BTN_LOAD]) begin
      if (sw_stable[SW_WIDTH-1]) inport_en[INPORT1] = 1'b1;
      else                       inport_en[INPORT0] = 1'b1;
    end
  end

  // Reset values match the post-reset debounced state, so neither reset
  // assertion nor release produces a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_dly_q <= '0;
      sw_prev_q   <= '0;
    end else begin
      level_dly_q <= level_dly_d;
      sw_prev_q   <= sw_prev_d;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with a short debounce window.
module tb_io_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  button_raw;
  logic [9:0]  switches_raw;
  logic [1:0]  button_level;
  logic [1:0]  button_press;
  logic [9:0]  switches_out;
  logic        switches_changed;
  logic [31:0] inport_data;
  logic [1:0]  inport_en;

  int total = 0;
  int bad   = 0;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .NUM_BTN         (2),
    .SW_WIDTH        (10),
    .DATA_WIDTH      (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .button_raw       (button_raw),
    .switches_raw     (switches_raw),
    .button_level     (button_level),
    .button_press     (button_press),
    .switches_out     (switches_out),
    .switches_changed (switches_changed),
    .inport_data      (inport_data),
    .inport_en        (inport_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  btn;
    logic [9:0]  sw;
    int          hold;
    logic [1:0]  lvl;
    logic [9:0]  swo;
    int          p0, p1, e0, e1, chg;
    logic [31:0] edata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs[14];

  initial begin
    int p0, p1, e0, e1, chg, first;
    logic [31:0] ed;

    //             btn    sw      hold lvl    swo     p0 p1 e0 e1 chg edata
    vecs[0]  = '{2'b11, 10'h000, 20, 2'b00, 10'h000, 0, 0, 0, 0, 0, 32'h0};
    vecs[1]  = '{2'b11, 10'h1FF, 12, 2'b00, 10'h1FF, 0, 0, 0, 0, 1, 32'h0};
    vecs[2]  = '{2'b11, 10'h0A5, 12, 2'b00, 10'h0A5, 0, 0, 0, 0, 1, 32'h0};
    vecs[3]  = '{2'b01, 10'h0A5, 12, 2'b10, 10'h0A5, 0, 1, 1, 0, 0, 32'h0A5};
    vecs[4]  = '{2'b11, 10'h0A5, 12, 2'b00, 10'h0A5, 0, 0, 0, 0, 0, 32'h0};
    vecs[5]  = '{2'b11, 10'h2A5, 12, 2'b00, 10'h2A5, 0, 0, 0, 0, 1, 32'h0};
    vecs[6]  = '{2'b01, 10'h2A5, 12, 2'b10, 10'h2A5, 0, 1, 0, 1, 0, 32'h0A5};
    vecs[7]  = '{2'b11, 10'h2A5, 12, 2'b00, 10'h2A5, 0, 0, 0, 0, 0, 32'h0};
    vecs[8]  = '{2'b00, 10'h2A5, 12, 2'b11, 10'h2A5, 1, 1, 0, 1, 0, 32'h0A5};
    vecs[9]  = '{2'b11, 10'h2A5, 12, 2'b00, 10'h2A5, 0, 0, 0, 0, 0, 32'h0};
    vecs[10] = '{2'b10, 10'h2A5, 12, 2'b01, 10'h2A5, 1, 0, 0, 0, 0, 32'h0};
    vecs[11] = '{2'b11, 10'h2A5, 12, 2'b00, 10'h2A5, 0, 0, 0, 0, 0, 32'h0};
    vecs[12] = '{2'b01, 10'h3FF, 12, 2'b10, 10'h3FF, 0, 1, 0, 1, 1, 32'h1FF};
    vecs[13] = '{2'b11, 10'h155, 12, 2'b00, 10'h155, 0, 0, 0, 0, 1, 32'h0};

    rst          = 1'b0;
    button_raw   = 2'b11;
    switches_raw = 10'h000;
    tick();
    tick();
    chk("reset level",   32'(button_level), 32'h0);
    chk("reset press",   32'(button_press), 32'h0);
    chk("reset swo",     32'(switches_out), 32'h0);
    chk("reset chg",     32'(switches_changed), 32'h0);
    chk("reset en",      32'(inport_en), 32'h0);
    chk("reset data",    inport_data, 32'h0);
    rst = 1'b1;

    for (int v = 0; v < 14; v++) begin
      button_raw   = vecs[v].btn;
      switches_raw = vecs[v].sw;
      p0 = 0; p1 = 0; e0 = 0; e1 = 0; chg = 0; ed = 32'h0;
      for (int t = 0; t < vecs[v].hold; t++) begin
        tick();
        if (button_press[0]) p0++;
        if (button_press[1]) p1++;
        if (inport_en[0]) e0++;
        if (inport_en[1]) e1++;
        if (switches_changed) chg++;
        if (|inport_en) ed = inport_data;
      end
      chk($sformatf("v%0d level", v), 32'(button_level), 32'(vecs[v].lvl));
      chk($sformatf("v%0d swo", v), 32'(switches_out), 32'(vecs[v].swo));
      chk($sformatf("v%0d data", v), inport_data, 32'(vecs[v].swo[8:0]));
      chk($sformatf("v%0d press0 cnt", v), p0, vecs[v].p0);
      chk($sformatf("v%0d press1 cnt", v), p1, vecs[v].p1);
      chk($sformatf("v%0d en0 cnt", v), e0, vecs[v].e0);
      chk($sformatf("v%0d en1 cnt", v), e1, vecs[v].e1);
      chk($sformatf("v%0d chg cnt", v), chg, vecs[v].chg);
      if (vecs[v].e0 + vecs[v].e1 > 0)
        chk($sformatf("v%0d en data", v), ed, vecs[v].edata);
    end

    // Bounce on button 0: runs of 3 never reach the 4-sample window.
    p0 = 0;
    for (int r = 0; r < 4; r++) begin
      button_raw[0] = r[0];
      for (int t = 0; t < ((r[0]) ? 1 : 3); t++) begin
        tick();
        if (button_press[0]) p0++;
      end
    end
    // Then held low: pulse expected on the 6th tick (edge E0+5).
    button_raw[0] = 1'b0;
    first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (button_press[0]) begin
        p0++;
        if (first == 0) first = t;
      end
    end
    chk("bounce press cnt", p0, 1);
    chk("bounce press tick", first, 6);
    button_raw = 2'b11;
    for (int t = 0; t < 12; t++) tick();
    chk("bounce released", 32'(button_level), 32'h0);

    // Reset mid-count discards the count and clears outputs at once.
    button_raw[0] = 1'b0;
    switches_raw  = 10'h000;
    tick();
    tick();
    chk("pre-reset swo", 32'(switches_out), 32'h155);
    rst = 1'b0;
    #1;
    chk("async reset swo", 32'(switches_out), 32'h0);
    chk("async reset data", inport_data, 32'h0);
    chk("async reset level", 32'(button_level), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    p0 = 0; chg = 0; first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (switches_changed) chg++;
      if (button_press[0]) begin
        p0++;
        if (first == 0) first = t;
      end
    end
    chk("post-reset press cnt", p0, 1);
    chk("post-reset press tick", first, 6);
    chk("post-reset chg cnt", chg, 0);
    chk("post-reset level", 32'(button_level), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
